mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory-side responder for the load-store buffer's io_* request interface. It also serves the
//  instruction-fetch unit. Each request becomes a little-endian byte-serial access on the
//  single-port 8-bit RAM/IO bus. Load results are sign- or zero-extended and returned as a
//  one-cycle result pulse; while a request is in flight, the block asserts stuck.
// PARAMETERS
//  ADDR_W   32     width of mem_a and of all request addresses
//  IO_SEL   2'b11  value of addr[17:16] that selects the memory-mapped IO region
// PORTS
//  clk_in        in   1       clock, rising edge
//  rst_in        in   1       asynchronous reset, active LOW
//  rdy_in        in   1       0 = freeze all state, force mem_wr=0
//  rob_clear     in   1       pipeline flush
//  lsb_req       in   1       one-cycle request pulse; sampled only when lsb_stuck=0
//  lsb_is_store  in   1       0 load, 1 store
//  lsb_addr      in   ADDR_W  byte address
//  lsb_data      in   32      store data (low bytes used)
//  lsb_op        in   3       funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  lsb_stuck     out  1       busy; combinational (state!=IDLE)
//  lsb_done      out  1       one-cycle completion pulse
//  lsb_res       out  32      load result, valid with lsb_done (0 for stores)
//  if_req        in   1       fetch request, level, held until if_done
//  if_addr       in   ADDR_W  fetch address (word)
//  if_done       out  1       one-cycle fetch completion pulse
//  if_inst       out  32      fetched word, valid with if_done
//  mem_din       in   8       RAM read data; 1-cycle latency after mem_a
//  mem_dout      out  8       RAM write data
//  mem_a         out  ADDR_W  RAM byte address
//  mem_wr        out  1       1 = write mem_dout to mem_a this cycle
//  io_buffer_full in  1       IO write FIFO full
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE, all counters=0.
//   Outputs: lsb_done=0, if_done=0, lsb_res=0, if_inst=0, mem_wr=0, mem_a=0, mem_dout=0.
//  States: IDLE, LD, ST, IF.
//   IDLE: lsb_req goes to LD or ST, latching addr/data/op; otherwise if_req goes to IF.
//   lsb_req wins over if_req in the same cycle.
//  Byte count n: b/bu=1, h/hu=2, w=4; IF always 4.
//  Byte i is at addr+i (i = 0..n-1, ADDR_W-bit add, wraps modulo 2^ADDR_W).
//  Timing is counted with the accepting cycle as cycle 0.
//  LD/IF timing:
//   - mem_a=addr+i is driven in cycle i+1.
//   - Byte i is captured from mem_din in cycle i+2.
//   - done pulses in cycle n+2; back to IDLE the same cycle.
//   - Result: byte0 in bits 7:0. b/h sign-extend from bit 8n-1; bu/hu/w zero-extend.
//  ST timing:
//   - mem_wr=1, mem_a=addr+i, mem_dout=lsb_data[8i+7:8i] in cycle i+1.
//   - lsb_done pulses in cycle n+1; lsb_res=0.
//  IO back-pressure: if a store address has addr[17:16]==IO_SEL and io_buffer_full=1, the
//   current byte is not written. mem_wr=0 and the counter holds until io_buffer_full=0.
//  mem_wr=0 in every cycle not writing a store byte. No new request is accepted in a done cycle.
//   In a done cycle lsb_stuck=1, so the next accept is at the earliest in the following cycle.
//  rob_clear in LD or IF: abort, return to IDLE next cycle, no done pulse.
//  rob_clear in ST: the store is committed, so all remaining bytes are written. lsb_done is
//   suppressed. lsb_stuck stays 1 until the last byte is written.
//  rob_clear in IDLE together with lsb_req/if_req: the request is ignored.
//  rdy_in=0: no state change and mem_wr=0. The current byte is re-driven when rdy_in returns;
//   a pending load byte is re-read.
//  Reset mid-operation aborts immediately, including a partial store.
// TESTING
//  lw @0x100, RAM 78 56 34 12 -> mem_a 0x100..0x103 in cycles 1-4; lsb_done cycle 6,
//   lsb_res=0x12345678.
//  lb @0x10 (RAM 0x80) -> lsb_res=0xFFFFFF80 in cycle 3; lbu -> 0x00000080;
//   lh of 0x8001 -> 0xFFFF8001.
//  sh data 0xABCD1234 @0x200 -> writes 0x34@0x200 (cycle 1) and 0x12@0x201 (cycle 2),
//   lsb_done cycle 3, 0x202 untouched.
//  lsb_req (lw) and if_req in same cycle -> LSB served first; IF accepted the cycle after
//   lsb_done; if_done 6 cycles later.
//  rob_clear in cycle 3 of lw -> no lsb_done, IDLE in cycle 4.
//   rob_clear in cycle 2 of sw -> all 4 bytes written, no lsb_done.
//  sb 0x41 @0x30000 with io_buffer_full=1 for cycles 1-3 -> mem_wr=0 in cycles 1-3;
//   write in cycle 4; lsb_done cycle 5.
//  rst_in low in cycle 2 of sw -> mem_wr=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//   Memory-side responder for the load-store buffer and the instruction-fetch
//   unit. Each request is turned into a little-endian byte-serial access on
//   the single-port 8-bit RAM/IO bus. Load results are sign- or zero-extended
//   and returned with a one-cycle done pulse.
//
// Ports
//   clk_in, rst_in (async, active low), rdy_in (0 = freeze)
//   rob_clear                 pipeline flush
//   lsb_req/lsb_is_store/lsb_addr/lsb_data/lsb_op   LSB request
//   lsb_stuck/lsb_done/lsb_res                       LSB status / result
//   if_req/if_addr, if_done/if_inst                  fetch request / result
//   mem_din, mem_dout, mem_a, mem_wr                 8-bit RAM/IO bus
//   io_buffer_full            IO write FIFO full (stalls IO-region stores)
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              lsb_req,
    input  logic              lsb_is_store,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_data,
    input  logic [2:0]        lsb_op,
    output logic              lsb_stuck,
    output logic              lsb_done,
    output logic [31:0]       lsb_res,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE,
        LD,
        ST,
        IF
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [31:0]        wdata;
    logic [2:0]         op;
    logic [2:0]         cnt;
    logic [31:0]        rbuf;
    logic               flushed;

    logic [2:0]         n_bytes;
    logic               store_blocked;
    logic               wr_now;
    logic [2:0]         adr_idx;
    logic [1:0]         cap_sel;
    logic [31:0]        rbuf_nxt;
    logic               sign_en;
    logic [31:0]        ld_val;

    always_comb begin
        if (state == IF) begin
            n_bytes = 3'd4;
        end else begin
            case (op[1:0])
                2'b00:   n_bytes = 3'd1;
                2'b01:   n_bytes = 3'd2;
                default: n_bytes = 3'd4;
            endcase
        end
    end

    // Step counter cnt: in LD/IF, cycle cnt+1 drives byte cnt and captures
    // byte cnt-1; cnt==n captures the last byte, cnt==n+1 is the done cycle.
    // In ST, cnt counts bytes written; cnt==n is the done cycle.
    always_comb begin
        store_blocked = (base[17:16] == IO_SEL) && io_buffer_full;
        wr_now        = (state == ST) && (cnt < n_bytes) && rdy_in && !store_blocked;

        // While frozen mid-load, point the bus at the byte still awaiting
        // capture so mem_din holds it again when rdy_in returns.
        adr_idx = cnt;
        if (!rdy_in && (state == LD || state == IF) && cnt != 3'd0 && cnt <= n_bytes) begin
            adr_idx = cnt - 3'd1;
        end
    end

    assign mem_a     = base + ADDR_W'(adr_idx);
    assign mem_wr    = wr_now;
    assign mem_dout  = (state == ST) ? wdata[{cnt[1:0], 3'b000} +: 8] : '0;
    assign lsb_stuck = (state != IDLE);

    always_comb begin
        cap_sel  = cnt[1:0] - 2'd1;
        rbuf_nxt = rbuf;
        rbuf_nxt[{cap_sel, 3'b000} +: 8] = mem_din;
        sign_en  = (state == LD) && !op[2];
        case (n_bytes)
            3'd1:    ld_val = {{24{sign_en & rbuf_nxt[7]}},  rbuf_nxt[7:0]};
            3'd2:    ld_val = {{16{sign_en & rbuf_nxt[15]}}, rbuf_nxt[15:0]};
            default: ld_val = rbuf_nxt;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            base     <= '0;
            wdata    <= '0;
            op       <= '0;
            cnt      <= '0;
            rbuf     <= '0;
            flushed  <= 1'b0;
            lsb_done <= 1'b0;
            lsb_res  <= '0;
            if_done  <= 1'b0;
            if_inst  <= '0;
        end else if (rdy_in) begin
            lsb_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rob_clear) begin
                        if (lsb_req) begin
                            state   <= lsb_is_store ? ST : LD;
                            base    <= lsb_addr;
                            wdata   <= lsb_data;
                            op      <= lsb_op;
                            cnt     <= '0;
                            flushed <= 1'b0;
                        end else if (if_req) begin
                            state   <= IF;
                            base    <= if_addr;
                            cnt     <= '0;
                            flushed <= 1'b0;
                        end
                    end
                end

                LD, IF: begin
                    if (rob_clear || cnt == n_bytes + 3'd1) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0) begin
                            rbuf <= rbuf_nxt;
                        end
                        if (cnt == n_bytes) begin
                            if (state == LD) begin
                                lsb_done <= 1'b1;
                                lsb_res  <= ld_val;
                            end else begin
                                if_done  <= 1'b1;
                                if_inst  <= ld_val;
                            end
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                ST: begin
                    // A flushed store is already committed: finish writing,
                    // but leave without a done pulse.
                    if (rob_clear) begin
                        flushed <= 1'b1;
                    end
                    if (cnt == n_bytes) begin
                        state <= IDLE;
                    end else if (wr_now) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == n_bytes - 3'd1) begin
                            if (rob_clear || flushed) begin
                                state <= IDLE;
                            end else begin
                                lsb_done <= 1'b1;
                                lsb_res  <= '0;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//   Self-checking bench for mem_ctrl. A byte-addressed RAM with one cycle of
//   read latency sits on the bus; a separate golden memory plus arithmetic
//   latency/extension rules predict every result, done cycle and RAM byte.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        lsb_req = 1'b0;
    logic        lsb_is_store = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_data = '0;
    logic [2:0]  lsb_op = '0;
    logic        lsb_stuck;
    logic        lsb_done;
    logic [31:0] lsb_res;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .lsb_req(lsb_req), .lsb_is_store(lsb_is_store), .lsb_addr(lsb_addr),
        .lsb_data(lsb_data), .lsb_op(lsb_op), .lsb_stuck(lsb_stuck),
        .lsb_done(lsb_done), .lsb_res(lsb_res), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_inst(if_inst), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    // Bus RAM and golden memory
    logic [7:0] ram  [bit [31:0]];
    logic [7:0] gold [bit [31:0]];
    logic [31:0] a_q = '0;
    logic        wr_q = 1'b0;
    logic [7:0]  d_q = '0;

    function automatic logic [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] gold_rd(input bit [31:0] a);
        return gold.exists(a) ? gold[a] : 8'h00;
    endfunction

    task automatic poke(input bit [31:0] a, input logic [7:0] b);
        ram[a]  = b;
        gold[a] = b;
    endtask

    always @(negedge clk_in) begin
        a_q  = mem_a;
        wr_q = mem_wr;
        d_q  = mem_dout;
    end

    always @(posedge clk_in) begin
        mem_din <= ram_rd(a_q);
        if (wr_q) ram[a_q] = d_q;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Little-endian value from golden memory, then sign extension by subtracting 2^(8n)
    function automatic logic [31:0] load_val(input logic [31:0] addr, input logic [2:0] op, input bit fetch);
        int n;
        logic [31:0] v;
        n = fetch ? 4 : nbytes(op);
        v = '0;
        for (int i = 0; i < n; i++) v = v + (32'(gold_rd(addr + 32'(i))) << (8 * i));
        if (!fetch && op == 3'b000 && v[7])  v = v - 32'h100;
        if (!fetch && op == 3'b001 && v[15]) v = v - 32'h10000;
        return v;
    endfunction

    // Done cycle: the first cycle after `need` productive cycles; a stalled
    // cycle and an IO-blocked cycle (cycles 1..blk) make no progress.
    function automatic int exp_cycle(input int need, input int stall_at, input int blk);
        int prog;
        prog = 0;
        for (int k = 1; k < 100; k++) begin
            if (prog == need) return k;
            if (k != stall_at && k > blk) prog++;
        end
        return -1;
    endfunction

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (lsb_stuck !== 1'b0 && w < 50) begin
            tick();
            w++;
        end
        check({tag, "/idle"}, 32'(lsb_stuck), 32'h0);
    endtask

    task automatic do_lsb(input string tag, input bit st, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int full_cyc, input int stall_at, input int clr_at);
        int n, exp_done, got_done, ndone, last;
        logic [31:0] exp_val, got_res;
        bit io;
        n        = nbytes(op);
        io       = (addr[17:16] == 2'b11);
        exp_val  = st ? 32'h0 : load_val(addr, op, 1'b0);
        exp_done = exp_cycle(st ? n : n + 1, stall_at, (st && io) ? full_cyc : 0);
        wait_idle(tag);
        lsb_req = 1'b1; lsb_is_store = st; lsb_addr = addr; lsb_data = data; lsb_op = op;
        rdy_in = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
        tick();
        lsb_req = 1'b0;
        got_done = 0; ndone = 0; got_res = '0;
        last = exp_done + 1;
        for (int k = 1; k <= last; k++) begin
            rdy_in         = (k != stall_at);
            io_buffer_full = (k <= full_cyc);
            rob_clear      = (k == clr_at);
            #1;
            if (lsb_done === 1'b1) begin
                ndone++;
                if (got_done == 0) begin
                    got_done = k;
                    got_res  = lsb_res;
                end
            end
            if (st && (k == stall_at || (io && k <= full_cyc)))
                check({tag, "/wr_hold"}, 32'(mem_wr), 32'h0);
            if (!st && stall_at == 0 && clr_at == 0 && k <= n)
                check({tag, "/rd_addr"}, mem_a, addr + 32'(k - 1));
            if (!st && clr_at != 0 && k == clr_at + 1)
                check({tag, "/clr_idle"}, 32'(lsb_stuck), 32'h0);
            tick();
        end
        rdy_in = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
        if (clr_at != 0) begin
            check({tag, "/no_done"}, 32'(ndone), 32'h0);
        end else begin
            check({tag, "/done_cyc"}, 32'(got_done), 32'(exp_done));
            check({tag, "/done_cnt"}, 32'(ndone), 32'h1);
            check({tag, "/res"}, got_res, exp_val);
        end
        if (st) begin
            for (int i = 0; i < n; i++) gold[addr + 32'(i)] = data[8*i +: 8];
            for (int i = 0; i <= n; i++)
                check({tag, "/ram"}, 32'(ram_rd(addr + 32'(i))), 32'(gold_rd(addr + 32'(i))));
        end
    endtask

    task automatic do_if(input string tag, input logic [31:0] addr, input int stall_at);
        int exp_done, got_done;
        logic [31:0] exp_val, got_val;
        exp_val  = load_val(addr, 3'b010, 1'b1);
        exp_done = exp_cycle(5, stall_at, 0);
        wait_idle(tag);
        if_req = 1'b1; if_addr = addr; rdy_in = 1'b1;
        tick();
        got_done = 0; got_val = '0;
        for (int k = 1; k <= exp_done + 1; k++) begin
            rdy_in = (k != stall_at);
            if_req = (got_done == 0);
            #1;
            if (if_done === 1'b1 && got_done == 0) begin
                got_done = k;
                got_val  = if_inst;
            end
            tick();
        end
        if_req = 1'b0; rdy_in = 1'b1;
        check({tag, "/done_cyc"}, 32'(got_done), 32'(exp_done));
        check({tag, "/inst"}, got_val, exp_val);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ld_ops [5];
        logic [31:0] addr, ld_r, if_r, exp_ld, exp_if;
        logic [2:0]  op;
        int ld_c, if_c, n, kind, stall;

        ld_ops[0] = 3'b000; ld_ops[1] = 3'b001; ld_ops[2] = 3'b010;
        ld_ops[3] = 3'b100; ld_ops[4] = 3'b101;

        for (int i = 0; i < 1024; i++) poke(32'(i), 8'($urandom));
        for (int i = 0; i < 256; i++)  poke(32'h30000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 256; i++)  poke(32'hFFFFFF00 + 32'(i), 8'($urandom));

        // Reset state
        tick(); tick(); tick();
        check("rst/stuck", 32'(lsb_stuck), 32'h0);
        check("rst/lsb_done", 32'(lsb_done), 32'h0);
        check("rst/if_done", 32'(if_done), 32'h0);
        check("rst/lsb_res", lsb_res, 32'h0);
        check("rst/if_inst", if_inst, 32'h0);
        check("rst/mem_wr", 32'(mem_wr), 32'h0);
        check("rst/mem_a", mem_a, 32'h0);
        check("rst/mem_dout", 32'(mem_dout), 32'h0);
        rst_in = 1'b1;
        tick();

        // Directed cases
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        do_lsb("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0);
        poke(32'h10, 8'h80);
        do_lsb("lb", 1'b0, 3'b000, 32'h10, 32'h0, 0, 0, 0);
        do_lsb("lbu", 1'b0, 3'b100, 32'h10, 32'h0, 0, 0, 0);
        poke(32'h20, 8'h01); poke(32'h21, 8'h80);
        do_lsb("lh", 1'b0, 3'b001, 32'h20, 32'h0, 0, 0, 0);
        do_lsb("lhu", 1'b0, 3'b101, 32'h20, 32'h0, 0, 0, 0);
        do_lsb("sh", 1'b1, 3'b001, 32'h200, 32'hABCD1234, 0, 0, 0);

        // LSB and fetch requested together
        exp_ld = load_val(32'h100, 3'b010, 1'b0);
        exp_if = load_val(32'h104, 3'b010, 1'b1);
        wait_idle("both");
        lsb_req = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h100; lsb_op = 3'b010;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        lsb_req = 1'b0;
        ld_c = 0; if_c = 0; ld_r = '0; if_r = '0;
        for (int k = 1; k <= 16; k++) begin
            if_req = (if_c == 0);
            #1;
            if (lsb_done === 1'b1 && ld_c == 0) begin ld_c = k; ld_r = lsb_res; end
            if (if_done === 1'b1 && if_c == 0)  begin if_c = k; if_r = if_inst; end
            tick();
        end
        if_req = 1'b0;
        check("both/lsb_cyc", 32'(ld_c), 32'd6);
        check("both/lsb_res", ld_r, exp_ld);
        check("both/if_cyc", 32'(if_c), 32'd13);
        check("both/if_inst", if_r, exp_if);

        do_lsb("lw_clr", 1'b0, 3'b010, 32'h140, 32'h0, 0, 0, 3);
        do_lsb("sw_clr", 1'b1, 3'b010, 32'h180, 32'h11223344, 0, 0, 2);
        do_lsb("sb_io", 1'b1, 3'b000, 32'h30000, 32'h00000041, 3, 0, 0);
        do_lsb("lw_stall", 1'b0, 3'b010, 32'h100, 32'h0, 0, 3, 0);
        do_lsb("sw_stall", 1'b1, 3'b010, 32'h1C0, 32'hCAFEF00D, 0, 2, 0);
        do_lsb("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h55AA33CC, 0, 0, 0);
        do_lsb("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 0, 0);
        do_if("if", 32'h104, 0);
        do_if("if_stall", 32'h108, 2);

        // Flush in IDLE cancels the request
        wait_idle("clr_idle");
        lsb_req = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h100; lsb_op = 3'b010; rob_clear = 1'b1;
        tick();
        lsb_req = 1'b0; rob_clear = 1'b0;
        #1;
        check("clr_idle/ignored", 32'(lsb_stuck), 32'h0);

        // Reset in the middle of a store
        wait_idle("rst_mid");
        lsb_req = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h280; lsb_data = 32'hDEADBEEF; lsb_op = 3'b010;
        tick();
        lsb_req = 1'b0;
        tick();
        rst_in = 1'b0;
        #1;
        check("rst_mid/mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mid/stuck", 32'(lsb_stuck), 32'h0);
        check("rst_mid/mem_a", mem_a, 32'h0);
        check("rst_mid/mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mid/lsb_res", lsb_res, 32'h0);
        tick();
        rst_in = 1'b1;
        tick();
        gold[32'h280] = 8'hEF;
        check("rst_mid/byte0", 32'(ram_rd(32'h280)), 32'(gold_rd(32'h280)));
        check("rst_mid/byte1", 32'(ram_rd(32'h281)), 32'(gold_rd(32'h281)));

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 2))
                0:       addr = 32'($urandom_range(0, 32'h3F8));
                1:       addr = 32'h30000 + 32'($urandom_range(0, 248));
                default: addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            endcase
            kind = $urandom_range(0, 4);
            if (kind <= 1) begin
                op    = ld_ops[$urandom_range(0, 4)];
                n     = nbytes(op);
                stall = ($urandom_range(0, 1) != 0) ? $urandom_range(1, n + 1) : 0;
                do_lsb("rnd_ld", 1'b0, op, addr, 32'h0, $urandom_range(0, 3), stall, 0);
            end else if (kind <= 3) begin
                op    = 3'($urandom_range(0, 2));
                n     = nbytes(op);
                stall = ($urandom_range(0, 1) != 0) ? $urandom_range(1, n) : 0;
                do_lsb("rnd_st", 1'b1, op, addr, $urandom, $urandom_range(0, 3), stall, 0);
            end else begin
                stall = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 5) : 0;
                do_if("rnd_if", addr, stall);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
